// File: rtl/wb_arbiter_nch.sv
// Round-robin Wishbone arbiter: N masters share the SDRAM controller slave port.
// Whole bus cycles are granted, gated by SDRAM init, with incrementing bursts capped at MAX_BURST beats.
//   state  | meaning
//   S_IDLE | no owner, slave port driven to zero, waiting for init_done and a request
//   S_OWN  | one master owns the bus until it drops cyc
module wb_arbiter_nch #(
    parameter int NCH       = 4,
    parameter int dw        = 32,
    parameter int APP_AW    = 26,
    parameter int MAX_BURST = 8
) (
    input  logic                    sys_clk,
    input  logic                    sdram_resetn,
    input  logic                    sdr_init_done,
    input  logic [NCH-1:0]          m_wb_cyc_i,
    input  logic [NCH-1:0]          m_wb_stb_i,
    input  logic [NCH-1:0]          m_wb_we_i,
    input  logic [NCH*APP_AW-1:0]   m_wb_addr_i,
    input  logic [NCH*dw-1:0]       m_wb_dat_i,
    input  logic [NCH*dw/8-1:0]     m_wb_sel_i,
    input  logic [NCH*3-1:0]        m_wb_cti_i,
    output logic [NCH-1:0]          m_wb_ack_o,
    output logic [dw-1:0]           m_wb_dat_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [APP_AW-1:0]       wb_addr_o,
    output logic [dw-1:0]           wb_dat_o,
    output logic [dw/8-1:0]         wb_sel_o,
    output logic [2:0]              wb_cti_o,
    input  logic                    wb_ack_i,
    input  logic [dw-1:0]           wb_dat_i,
    output logic [NCH-1:0]          grant_o
);

    localparam int LW = $clog2(NCH);
    localparam int BW = $clog2(MAX_BURST);
    localparam int SW = dw / 8;

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t          state, state_nxt;
    logic [NCH-1:0]  grant, grant_nxt;
    logic [LW-1:0]   last_owner, last_owner_nxt;
    logic [BW-1:0]   beat_cnt, beat_cnt_nxt;
    logic [LW-1:0]   pick_idx;
    logic            pick_found;
    logic            own_cyc;
    logic [2:0]      own_cti;

    // last_owner doubles as the current owner index while in S_OWN
    assign own_cyc = m_wb_cyc_i[last_owner];
    assign own_cti = m_wb_cti_i[int'(last_owner)*3 +: 3];

    always_comb begin : rr_pick
        logic [LW-1:0] cand;
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = LW'((int'(last_owner) + k) % NCH);
            if (!pick_found && m_wb_cyc_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_owner <= LW'(NCH - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_owner_nxt = last_owner;
        case (state)
            S_IDLE: begin
                if (sdr_init_done && pick_found) begin
                    state_nxt           = S_OWN;
                    grant_nxt           = '0;
                    grant_nxt[pick_idx] = 1'b1;
                    last_owner_nxt      = pick_idx;
                end
            end
            S_OWN: begin
                if (!own_cyc) begin
                    if (sdr_init_done && pick_found) begin
                        grant_nxt           = '0;
                        grant_nxt[pick_idx] = 1'b1;
                        last_owner_nxt      = pick_idx;
                    end else begin
                        state_nxt = S_IDLE;
                        grant_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase

        // Counter width equals log2(MAX_BURST), so the capped beat wraps it to zero naturally
        if (state_nxt != S_OWN || grant_nxt != grant || own_cti != 3'b010)
            beat_cnt_nxt = '0;
        else if (wb_ack_i)
            beat_cnt_nxt = beat_cnt + 1'b1;
        else
            beat_cnt_nxt = beat_cnt;
    end

    always_comb begin
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_addr_o = '0;
        wb_dat_o  = '0;
        wb_sel_o  = '0;
        wb_cti_o  = 3'b000;
        if (state == S_OWN) begin
            wb_cyc_o  = own_cyc;
            wb_stb_o  = m_wb_stb_i[last_owner] & own_cyc;
            wb_we_o   = m_wb_we_i[last_owner];
            wb_addr_o = m_wb_addr_i[int'(last_owner)*APP_AW +: APP_AW];
            wb_dat_o  = m_wb_dat_i[int'(last_owner)*dw +: dw];
            wb_sel_o  = m_wb_sel_i[int'(last_owner)*SW +: SW];
            wb_cti_o  = (own_cti == 3'b010 && beat_cnt == BW'(MAX_BURST - 1)) ? 3'b111 : own_cti;
        end
    end

    assign m_wb_ack_o = {NCH{wb_ack_i}} & grant;
    assign m_wb_dat_o = wb_dat_i;
    assign grant_o    = grant;

endmodule

// File: tb/tb_wb_arbiter_nch.sv
// Bench for wb_arbiter_nch: directed scenarios plus random traffic, every cycle checked
// against a queue of expected outputs produced by an integer-level model of the arbiter.
module tb_wb_arbiter_nch;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 26;
    localparam int MB  = 8;
    localparam int SW  = DW / 8;

    logic              sys_clk = 1'b0;
    logic              sdram_resetn, sdr_init_done;
    logic [NCH-1:0]    m_cyc, m_stb, m_we;
    logic [NCH*AW-1:0] m_addr;
    logic [NCH*DW-1:0] m_dat;
    logic [NCH*SW-1:0] m_sel;
    logic [NCH*3-1:0]  m_cti;
    logic [NCH-1:0]    m_ack;
    logic [DW-1:0]     m_rdat;
    logic              wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0]     wb_addr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [SW-1:0]     wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic              wb_ack_i;
    logic [DW-1:0]     wb_dat_i;
    logic [NCH-1:0]    grant_o;

    wb_arbiter_nch #(.NCH(NCH), .dw(DW), .APP_AW(AW), .MAX_BURST(MB)) dut (
        .sys_clk(sys_clk), .sdram_resetn(sdram_resetn), .sdr_init_done(sdr_init_done),
        .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we), .m_wb_addr_i(m_addr),
        .m_wb_dat_i(m_dat), .m_wb_sel_i(m_sel), .m_wb_cti_i(m_cti),
        .m_wb_ack_o(m_ack), .m_wb_dat_o(m_rdat),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
        .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .grant_o(grant_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [NCH-1:0] grant;
        logic [NCH-1:0] ack;
        logic           cyc;
        logic           stb;
        logic           we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  dat;
        logic [DW-1:0]  rdat;
        logic [SW-1:0]  sel;
        logic [2:0]     cti;
    } exp_t;

    exp_t q[$];
    int   tests, fails;
    int   owner, last, beats;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int from);
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (from + k) % NCH;
            if (m_cyc[c]) return c;
        end
        return -1;
    endfunction

    // Advance the model across one rising edge using the inputs present at that edge
    task automatic model_edge();
        int p;
        if (!sdram_resetn) begin
            owner = -1; last = NCH - 1; beats = 0;
        end else if (owner < 0) begin
            p = sdr_init_done ? rr_pick(last) : -1;
            if (p >= 0) begin owner = p; last = p; beats = 0; end
        end else if (!m_cyc[owner]) begin
            p = sdr_init_done ? rr_pick(owner) : -1;
            owner = p;
            if (p >= 0) last = p;
            beats = 0;
        end else if (m_cti[owner*3 +: 3] == 3'b010) begin
            if (wb_ack_i) beats = (beats + 1) % MB;
        end else begin
            beats = 0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic [2:0] c;
        e = '0;
        e.rdat = wb_dat_i;
        if (owner >= 0) begin
            e.grant = NCH'(1) << owner;
            e.ack   = wb_ack_i ? e.grant : '0;
            e.cyc   = m_cyc[owner];
            e.stb   = m_stb[owner] & m_cyc[owner];
            e.we    = m_we[owner];
            e.addr  = m_addr[owner*AW +: AW];
            e.dat   = m_dat[owner*DW +: DW];
            e.sel   = m_sel[owner*SW +: SW];
            c       = m_cti[owner*3 +: 3];
            e.cti   = (c == 3'b010 && beats == MB - 1) ? 3'b111 : c;
        end
        return e;
    endfunction

    // Inputs for this cycle are already applied; queue expectation, cross the edge
    task automatic tick();
        if (!sdram_resetn) begin owner = -1; last = NCH - 1; beats = 0; end
        q.push_back(model_out());
        @(posedge sys_clk);
        #1;
        model_edge();
    endtask

    task automatic set_ch(input int i, input logic c, input logic s, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] sl, input logic [2:0] ct);
        m_cyc[i] = c; m_stb[i] = s; m_we[i] = w;
        m_addr[i*AW +: AW] = a; m_dat[i*DW +: DW] = d;
        m_sel[i*SW +: SW] = sl; m_cti[i*3 +: 3] = ct;
    endtask

    task automatic clear_all();
        m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_dat = '0; m_sel = '0; m_cti = '0;
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("grant_o",    grant_o,   e.grant);
            check("m_wb_ack_o", m_ack,     e.ack);
            check("m_wb_dat_o", m_rdat,    e.rdat);
            check("wb_cyc_o",   wb_cyc_o,  e.cyc);
            check("wb_stb_o",   wb_stb_o,  e.stb);
            check("wb_we_o",    wb_we_o,   e.we);
            check("wb_addr_o",  wb_addr_o, e.addr);
            check("wb_dat_o",   wb_dat_o,  e.dat);
            check("wb_sel_o",   wb_sel_o,  e.sel);
            check("wb_cti_o",   wb_cti_o,  e.cti);
        end
    end

    initial begin
        logic [NCH-1:0] order[$];
        logic [NCH-1:0] prevg;
        logic [19:0]    capmask;
        logic [2:0]     ctis[5];
        int             hold;
        int             rem[NCH];
        logic [2:0]     tcti[NCH];

        tests = 0; fails = 0;
        owner = -1; last = NCH - 1; beats = 0;
        sdram_resetn = 1'b0; sdr_init_done = 1'b0;
        clear_all();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        ctis = '{3'b000, 3'b010, 3'b010, 3'b111, 3'b001};
        for (int i = 0; i < NCH; i++) begin rem[i] = 0; tcti[i] = 3'b000; end
        @(posedge sys_clk); #1;

        // Reset, then requests gated by init_done
        tick(); tick();
        check("reset_grant", grant_o, '0);
        sdram_resetn = 1'b1;
        set_ch(1, 1, 1, 0, 26'h10, 32'h1111, 4'hF, 3'b000);
        tick(); tick(); tick();
        check("init_gate_grant", grant_o, '0);
        check("init_gate_cyc", wb_cyc_o, 1'b0);
        sdr_init_done = 1'b1;
        tick();
        check("init_grant", grant_o, 4'b0010);
        tick();
        clear_all();
        tick(); tick();

        // All channels from reset: rotation 0,1,2,3,0
        sdram_resetn = 1'b0; tick(); sdram_resetn = 1'b1;
        for (int i = 0; i < NCH; i++) set_ch(i, 1, 1, 0, AW'($urandom), $urandom, 4'hF, 3'b000);
        hold = 0; prevg = '0;
        for (int n = 0; n < 24; n++) begin
            wb_ack_i = 1'($urandom % 2); wb_dat_i = $urandom;
            m_cyc = '1;
            if (owner >= 0) begin
                if (hold == 2) begin m_cyc[owner] = 1'b0; hold = 0; end
                else hold++;
            end
            tick();
            if (grant_o != prevg && grant_o != '0) order.push_back(grant_o);
            prevg = grant_o;
        end
        if (order.size() >= 5) begin
            check("rr_order0", order[0], 4'b0001);
            check("rr_order1", order[1], 4'b0010);
            check("rr_order2", order[2], 4'b0100);
            check("rr_order3", order[3], 4'b1000);
            check("rr_order4", order[4], 4'b0001);
        end else begin
            check("rr_order_count", order.size(), 5);
        end
        clear_all(); wb_ack_i = 1'b0;
        tick(); tick();

        // ch2 single write
        set_ch(2, 1, 1, 1, 26'h0001234, 32'hDEADBEEF, 4'hF, 3'b000);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
        #1;
        check("wr_ack", m_ack, 4'b0100);
        check("wr_addr", wb_addr_o, 26'h0001234);
        check("wr_dat", wb_dat_o, 32'hDEADBEEF);
        check("wr_sel", wb_sel_o, 4'hF);
        check("wr_rdat", m_rdat, 32'hCAFEF00D);
        tick();
        clear_all(); wb_ack_i = 1'b0;
        tick(); tick();

        // ch0 20-beat incrementing burst, cap at beats 8 and 16
        set_ch(0, 1, 1, 0, 26'h100, 32'h0, 4'hF, 3'b010);
        tick();
        wb_ack_i = 1'b1; capmask = '0;
        for (int b = 0; b < 20; b++) begin
            m_addr[0 +: AW] = AW'(26'h100 + b * 4);
            m_dat[0 +: DW]  = $urandom;
            #1;
            if (wb_cti_o == 3'b111) capmask[b] = 1'b1;
            tick();
        end
        check("burst_cap_beats", capmask, 20'h08080);
        clear_all(); wb_ack_i = 1'b0;
        tick(); tick();

        // Reset mid-burst on ch3
        set_ch(3, 1, 1, 0, 26'h300, 32'h3, 4'hF, 3'b010);
        tick();
        wb_ack_i = 1'b1;
        tick(); tick(); tick();
        sdram_resetn = 1'b0;
        #1;
        check("rst_grant", grant_o, '0);
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_ack", m_ack, '0);
        tick();
        for (int i = 0; i < NCH; i++) set_ch(i, 1, 1, 0, AW'(i), 32'h0, 4'hF, 3'b000);
        sdram_resetn = 1'b1;
        tick();
        check("post_rst_grant", grant_o, 4'b0001);
        clear_all(); wb_ack_i = 1'b0;
        tick(); tick();

        // init_done drops during ch1 ownership
        set_ch(1, 1, 1, 0, 26'h11, 32'h1, 4'hF, 3'b000);
        tick();
        set_ch(2, 1, 1, 0, 26'h22, 32'h2, 4'hF, 3'b000);
        sdr_init_done = 1'b0;
        tick(); tick(); tick();
        check("init_drop_keep", grant_o, 4'b0010);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick(); tick();
        check("init_drop_block", grant_o, '0);
        sdr_init_done = 1'b1;
        tick();
        check("init_back_grant", grant_o, 4'b0100);
        clear_all();
        tick(); tick();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NCH; i++) begin
                m_we[i] = 1'($urandom % 2);
                m_addr[i*AW +: AW] = AW'($urandom);
                m_dat[i*DW +: DW]  = $urandom;
                m_sel[i*SW +: SW]  = SW'($urandom);
                if (rem[i] > 0) begin
                    m_cyc[i] = 1'b1;
                    m_stb[i] = ($urandom % 4) != 0;
                    m_cti[i*3 +: 3] = tcti[i];
                    if (owner == i) rem[i]--;
                end else begin
                    m_cyc[i] = 1'b0;
                    m_stb[i] = 1'($urandom % 2);
                    m_cti[i*3 +: 3] = 3'($urandom);
                    if ($urandom % 3 == 0) begin
                        rem[i]  = $urandom_range(1, 24);
                        tcti[i] = ctis[$urandom % 5];
                    end
                end
            end
            wb_ack_i      = ($urandom % 4) != 0;
            wb_dat_i      = $urandom;
            sdr_init_done = ($urandom % 40) != 0;
            sdram_resetn  = ($urandom % 400) != 0;
            tick();
        end
        sdram_resetn = 1'b1;
        clear_all();
        tick();
        @(negedge sys_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_arbiter_nch.md
# wb_arbiter_nch

Parametrised N-channel Wishbone arbiter placed between several Wishbone masters (test drivers, DMA engines, CPU port) and the single Wishbone slave port of the SDRAM controller. Grants whole bus cycles round-robin, gates all grants until SDRAM initialisation completes, routes acknowledges back to the owning master, and caps incrementing bursts at a programmable beat count so the controller never sees an unbounded burst.

## Interface

Parameters:
- NCH, 4, number of master channels (2..16)
- dw, 32, Wishbone data width (multiple of 8)
- APP_AW, 26, Wishbone address width
- MAX_BURST, 8, maximum beats per incrementing burst presented to the slave (power of 2, ≥2)

Ports (clock and reset first):
- sys_clk  in  1  system clock; all logic on rising edge
- sdram_resetn  in  1  reset, asynchronous, active-low
- sdr_init_done  in  1  SDRAM init complete; no new grant while low
- m_wb_cyc_i  in  NCH  per-master cycle request
- m_wb_stb_i  in  NCH  per-master strobe
- m_wb_we_i  in  NCH  per-master write enable
- m_wb_addr_i  in  NCH*APP_AW  per-master address, channel i at [i*APP_AW +: APP_AW]
- m_wb_dat_i  in  NCH*dw  per-master write data
- m_wb_sel_i  in  NCH*dw/8  per-master byte enables
- m_wb_cti_i  in  NCH*3  per-master cycle type
- m_wb_ack_o  out  NCH  per-master acknowledge
- m_wb_dat_o  out  dw  read data, broadcast to all masters
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  to slave
- wb_addr_o  out  APP_AW; wb_dat_o  out  dw; wb_sel_o  out  dw/8; wb_cti_o  out  3  to slave
- wb_ack_i  in  1; wb_dat_i  in  dw  from slave
- grant_o  out  NCH  one-hot current owner (all zero when idle)

## Operation

- FSM states: IDLE, OWN. Registers: state, grant (one-hot), last_owner (log2 NCH), beat_cnt (log2 MAX_BURST).
- IDLE: if sdr_init_done=1 and any m_wb_cyc_i set, pick first requester searching from last_owner+1 upward, wrapping modulo NCH; load grant, last_owner; go OWN.
- OWN: slave outputs = owner's inputs (combinational mux); wb_cyc_o = owner cyc; wb_stb_o = owner stb & owner cyc. Non-owners receive m_wb_ack_o=0.
- m_wb_ack_o[i] = wb_ack_i & grant[i]; m_wb_dat_o = wb_dat_i always.
- Release: owner cyc sampled low at edge → if sdr_init_done and another cyc pending, grant next requester (same search, starting after releasing owner) directly, stay OWN; else IDLE, grant cleared.
- Ownership is never preempted while owner cyc is high.
- Burst cap: while owner cti=3'b010, beat_cnt increments on each wb_ack_i; when beat_cnt=MAX_BURST-1, wb_cti_o forced to 3'b111; that ack wraps beat_cnt to 0, next beat restarts as 3'b010. beat_cnt cleared on grant change or when owner cti≠3'b010. Other cti values pass unchanged.
- sdr_init_done falling in OWN does not revoke current grant; it blocks the next grant only.
- In IDLE all slave outputs 0.

## Timing

- Reset (async assert, sync deassert expected externally): state=IDLE, grant_o=0, last_owner=NCH-1 (channel 0 first), beat_cnt=0; wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_addr_o, wb_dat_o, wb_sel_o, m_wb_ack_o all 0. Reset mid-burst aborts instantly; no ack delivered.
- Grant latency: cyc rising at cycle t in IDLE → grant_o and wb_cyc_o high in t+1.
- Handover: owner drops cyc in cycle t (wb_cyc_o low in t) → new owner on bus in t+1; exactly one bus-idle cycle between owners.
- Ack path combinational, zero added latency; write/read data combinational.
- Simultaneous requests resolved by round-robin pointer only; a master holding cyc continuously is served at most once per rotation when others wait.

## Test plan

- Reset, sdr_init_done=0, ch1 cyc=1 → grant_o stays 0, wb_cyc_o=0; raise sdr_init_done → grant_o=4'b0010 next cycle.
- All four channels request from reset → grant order ch0,ch1,ch2,ch3,ch0, each handover one idle cycle, acks only to owner.
- ch2 single write addr 0x000_1234, dat 0xDEADBEEF, sel 4'hF → slave sees identical values; m_wb_ack_o=4'b0100 on slave ack; m_wb_dat_o follows wb_dat_i.
- ch0 incrementing burst of 20 beats, MAX_BURST=8 → wb_cti_o=3'b111 on beats 8 and 16, 3'b010 elsewhere; beat_cnt 0 at beat 17.
- Assert sdram_resetn=0 mid-burst on ch3 → same cycle grant_o=0, wb_cyc_o=0, all acks 0; after release ch0 wins first.
- sdr_init_done drops during ch1 ownership → ch1 completes; ch2 pending not granted until sdr_init_done=1 again.
